// File: rtl/dsa_mem_arbiter_if.sv
// Requester/memory bus bundle for dsa_mem_arbiter: three packed requester lanes plus the
// single-port RAM command/return path.
interface dsa_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 8
);
   logic [2:0]              req;
   logic [2:0]              we;
   logic [2:0]              lock;
   logic [3*ADDR_WIDTH-1:0] addr;
   logic [3*DATA_WIDTH-1:0] wdata;
   logic [2:0]              gnt;
   logic [2:0]              rvalid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    mem_en;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   modport master (
      output req, we, lock, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req, we, lock, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dsa_mem_arbiter.sv
// Round-robin single-port image memory arbiter with bounded bus lock and fixed read latency.
// Optional per-requester performance counters are built when DSA_ARB_PERF_EN is defined.
module dsa_mem_arbiter #(
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LOCK   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   dsa_mem_arbiter_if.slave  bus,
`ifdef DSA_ARB_PERF_EN
   input  logic              perf_clr,
   output logic [2:0][31:0]  perf_grants,
   output logic [2:0][31:0]  perf_stall,
`endif
   output logic              busy
);
   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t                  state, state_nxt;
   logic [1:0]              rr_ptr, rr_ptr_nxt;
   logic [1:0]              owner, owner_nxt;
   logic [CNT_W-1:0]        lock_cnt, lock_cnt_nxt;
   logic [2:0]              gnt;
   logic                    gnt_any;
   logic [1:0]              gnt_id;
   logic [1:0]              cand;

   logic                    mem_en_p1, mem_we_p1;
   logic [ADDR_WIDTH-1:0]   mem_addr_p1;
   logic [DATA_WIDTH-1:0]   mem_wdata_p1;
   logic                    vld_p1, vld_p2;
   logic [1:0]              id_p1, id_p2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= 2'd0;
         owner    <= 2'd0;
         lock_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         owner    <= owner_nxt;
         lock_cnt <= lock_cnt_nxt;
      end
   end

   // Grant is combinational from req; a locked owner that stops locking forfeits one cycle.
   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      owner_nxt    = owner;
      lock_cnt_nxt = lock_cnt;
      gnt          = '0;
      gnt_any      = 1'b0;
      gnt_id       = 2'd0;
      cand         = 2'd0;
      if (rst_n) begin
         unique case (state)
            IDLE: begin
               for (int k = 0; k < 3; k++) begin
                  cand = 2'((int'(rr_ptr) + k) % 3);
                  if (!gnt_any && bus.req[cand]) begin
                     gnt_any = 1'b1;
                     gnt_id  = cand;
                  end
               end
               if (gnt_any) begin
                  gnt[gnt_id] = 1'b1;
                  rr_ptr_nxt  = (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
                  if (bus.lock[gnt_id] && MAX_LOCK > 1) begin
                     state_nxt    = LOCKED;
                     owner_nxt    = gnt_id;
                     lock_cnt_nxt = CNT_W'(1);
                  end
               end
            end
            LOCKED: begin
               state_nxt    = IDLE;
               lock_cnt_nxt = '0;
               if (bus.req[owner] && bus.lock[owner]) begin
                  gnt_any    = 1'b1;
                  gnt_id     = owner;
                  gnt[owner] = 1'b1;
                  if (lock_cnt + CNT_W'(1) != CNT_W'(MAX_LOCK)) begin
                     state_nxt    = LOCKED;
                     lock_cnt_nxt = lock_cnt + CNT_W'(1);
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ---- stage p1: registered memory command and read-owner tag ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_en_p1    <= 1'b0;
         mem_we_p1    <= 1'b0;
         mem_addr_p1  <= '0;
         mem_wdata_p1 <= '0;
         vld_p1       <= 1'b0;
      end else begin
         mem_en_p1 <= gnt_any;
         mem_we_p1 <= gnt_any & bus.we[gnt_id];
         vld_p1    <= gnt_any & ~bus.we[gnt_id];
         if (gnt_any) begin
            mem_addr_p1  <= bus.addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_p1 <= bus.wdata[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // ---- stage p2: read data returns from the RAM alongside the delayed tag ----
   always_ff @(posedge clk) begin
      if (!rst_n) vld_p2 <= 1'b0;
      else        vld_p2 <= vld_p1;
   end

   always_ff @(posedge clk) begin
      id_p1 <= gnt_id;
      id_p2 <= id_p1;
   end

   assign bus.gnt       = gnt;
   assign bus.mem_en    = mem_en_p1;
   assign bus.mem_we    = mem_we_p1;
   assign bus.mem_addr  = mem_addr_p1;
   assign bus.mem_wdata = mem_wdata_p1;
   assign bus.rvalid    = vld_p2 ? (3'b001 << id_p2) : 3'b000;
   assign bus.rdata     = bus.mem_rdata;
   assign busy          = (state == LOCKED) | mem_en_p1 | vld_p1 | vld_p2;

`ifdef DSA_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n || perf_clr) begin
         perf_grants <= '0;
         perf_stall  <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            perf_grants[i] <= perf_grants[i] + 32'(gnt[i]);
            perf_stall[i]  <= perf_stall[i] + 32'(bus.req[i] & ~gnt[i]);
         end
      end
   end
`endif
endmodule

// File: doc/dsa_mem_arbiter.md
Name: dsa_mem_arbiter

Overview:
- Shares the single-port image memory between three requesters: host/debug (0), SIMD fetch unit (1), SIMD write-back (2).
- Round-robin arbitration with optional bus lock, so fetch can issue back-to-back neighbour-pixel reads and write-back can drain SIMD_WIDTH pixels uninterrupted.
- Sits between the control FSM's fetch/write-back engines and the on-chip RAM.
- Registered memory command; fixed read-return latency.

Parameters:
- ADDR_WIDTH, 18, memory word address width
- DATA_WIDTH, 8, memory word width (one pixel)
- MAX_LOCK, 16, maximum consecutive grants to a locking owner before forced release (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- req  in  3  per-requester access request; bit i = requester i
- we  in  3  per-requester write enable (1 = write, 0 = read)
- lock  in  3  per-requester lock request; meaningful only with req
- addr  in  3*ADDR_WIDTH  per-requester address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  3*DATA_WIDTH  per-requester write data, same slicing
- gnt  out  3  one-hot grant, combinational, at most one bit set
- rvalid  out  3  one-hot read-data-valid
- rdata  out  DATA_WIDTH  read data, shared by all requesters; qualified by rvalid
- mem_en  out  1  registered memory access strobe
- mem_we  out  1  registered memory write enable
- mem_addr  out  ADDR_WIDTH  registered memory address
- mem_wdata  out  DATA_WIDTH  registered memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_en with mem_we=0
- busy  out  1  high while LOCKED, while a command is in flight, or while any rvalid is pending

Behaviour:
- Reset (rst_n=0 at clk edge):
  - mem_en/mem_we=0; mem_addr/mem_wdata=0; rvalid=0; state=IDLE; rr_ptr=0; lock_cnt=0.
  - Any in-flight read is discarded; no rvalid is produced for it.
  - gnt=0 throughout reset.
- Handshake:
  - Requester holds req/we/addr/wdata/lock stable until it sees gnt in the same cycle; the transfer occurs on that edge.
  - gnt is never asserted without req.
- Latency, grant in cycle T:
  - mem_* command registered, visible in T+1.
  - For reads, rvalid[i]=1 and rdata=mem_rdata in T+2.
  - One access per cycle maximum; full throughput, back-to-back grants allowed.
  - rvalid is driven by a 2-stage owner-tag pipeline (valid bit + 2-bit id).
- State machine:
  - IDLE:
    - Round-robin over req, starting at index rr_ptr, ascending and wrapping 2->0.
    - Grant first set bit; rr_ptr <= winner+1 mod 3.
    - If winner's lock=1 and MAX_LOCK>1: go to LOCKED, owner<=winner, lock_cnt<=1.
  - LOCKED:
    - Only owner eligible. Others see gnt=0 even if requesting.
    - If req[owner]&lock[owner]: grant, lock_cnt++.
    - When lock_cnt reaches MAX_LOCK on a grant: return to IDLE (forced release). The owner competes normally afterwards, and rr_ptr already points past it.
    - If req[owner]=0 or lock[owner]=0 in a cycle: no grant to owner that cycle. Return to IDLE; arbitration restarts next cycle. Cycle lost intentionally to keep gnt timing simple.
    - If req[owner]=1, lock[owner]=0: not granted this cycle. Re-arbitrated in IDLE.
- Locking behaviour:
  - Lock sampled only with a grant; lock without req is ignored.
  - Reads and writes may be mixed within a locked sequence.
- Simultaneous events:
  - Write granted at T, read to same address at T+1: read returns the new data (memory is write-first/serialized).
  - Arbiter does no hazard checking.
- Width rule: lock_cnt is $clog2(MAX_LOCK+1) bits, saturating never needed because release occurs at MAX_LOCK.
- MAX_LOCK=1: lock is effectively ignored; pure round-robin.

Optional Feature:
- Macro: DSA_ARB_PERF_EN.
- When defined, adds outputs:
  - perf_grants: 3x32 bits, grants per requester.
  - perf_stall: 3x32 bits, cycles with req[i]=1 and gnt[i]=0.
  - perf_clr: input, synchronous clear.
  - All counters wrap at 2^32, reset to 0.
- When undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single read: req=3'b010, addr[1]=0x00100, mem returns 0x5A → gnt=010 at T; mem_en=1,mem_we=0,mem_addr=0x00100 at T+1; rvalid=010, rdata=0x5A at T+2.
- Contention: req=3'b111 held for 6 grants from reset (rr_ptr=0) → grant order 0,1,2,0,1,2; every requester gets exactly 2 grants.
- Lock burst: requester 1 req+lock held, requester 2 req held, MAX_LOCK=4 → four consecutive gnt=010, then gnt=100, proving forced release.
- Early unlock: requester 2 locks, writes 2 pixels, drops lock → one idle cycle with gnt=0, then normal round-robin; 2 mem writes with correct addr/wdata.
- Reset mid-read: grant read at T, rst_n=0 at T+1 → no rvalid at T+2, mem_en=0, busy=0 after reset.
- With DSA_ARB_PERF_EN: req=111 for 9 cycles → perf_grants = 3,3,3; perf_stall = 6,6,6; perf_clr → all 0 next cycle.
